// File: rtl/mem_access.sv
// Memory-access stage: issues one load/store per instruction on a valid/data_ok bus,
// aligns store lanes, formats load data, and stalls execute while a request is open.
module mem_access (
    input  logic        clk,
    input  logic        reset,
    input  logic        valid,
    input  logic [63:0] alu_result,
    input  logic [63:0] wdata,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [1:0]  msize,
    input  logic        load_unsigned,
    output logic        dreq_valid,
    output logic [63:0] dreq_addr,
    output logic [1:0]  dreq_size,
    output logic        dreq_write,
    output logic [7:0]  dreq_strobe,
    output logic [63:0] dreq_data,
    input  logic        dresp_data_ok,
    input  logic [63:0] dresp_data,
    output logic [63:0] result,
    output logic        done,
    output logic        misalign,
    output logic        bubble
);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} state_t;

    state_t      r_state;
    state_t      w_next;

    logic [63:0] r_addr;
    logic [1:0]  r_size;
    logic        r_write;
    logic [7:0]  r_strobe;
    logic [63:0] r_data;
    logic        r_unsigned;
    logic [63:0] r_result;

    logic        w_memop;
    logic        w_misaligned;
    logic [2:0]  w_off;
    logic [7:0]  w_strobe;
    logic [63:0] w_sdata;
    logic        w_accept;
    logic [63:0] w_ld_shift;
    logic [63:0] w_ld_fmt;

    assign w_memop = mem_read | mem_write;
    assign w_off   = alu_result[2:0];
    assign w_sdata = wdata << {w_off, 3'b000};

    always_comb begin
        w_misaligned = 1'b0;
        w_strobe     = '0;
        case (msize)
            2'd0: begin
                w_misaligned = 1'b0;
                w_strobe     = 8'h01 << w_off;
            end
            2'd1: begin
                w_misaligned = alu_result[0];
                w_strobe     = 8'h03 << w_off;
            end
            2'd2: begin
                w_misaligned = alu_result[1:0] != 2'b00;
                w_strobe     = 8'h0F << w_off;
            end
            default: begin
                w_misaligned = alu_result[2:0] != 3'b000;
                w_strobe     = 8'hFF;
            end
        endcase
    end

    assign w_accept = (r_state == S_IDLE) && valid && w_memop && !w_misaligned;

    // Load formatting works off the latched request, not the live inputs.
    assign w_ld_shift = dresp_data >> {r_addr[2:0], 3'b000};

    always_comb begin
        w_ld_fmt = w_ld_shift;
        case (r_size)
            2'd0:    w_ld_fmt = {{56{w_ld_shift[7]  & ~r_unsigned}}, w_ld_shift[7:0]};
            2'd1:    w_ld_fmt = {{48{w_ld_shift[15] & ~r_unsigned}}, w_ld_shift[15:0]};
            2'd2:    w_ld_fmt = {{32{w_ld_shift[31] & ~r_unsigned}}, w_ld_shift[31:0]};
            default: w_ld_fmt = w_ld_shift;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (w_accept) w_next = S_WAIT;
            S_WAIT:  if (dresp_data_ok) w_next = S_DONE;
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_addr     <= '0;
            r_size     <= '0;
            r_write    <= 1'b0;
            r_strobe   <= '0;
            r_data     <= '0;
            r_unsigned <= 1'b0;
            r_result   <= '0;
        end else begin
            if (w_accept) begin
                r_addr     <= alu_result;
                r_size     <= msize;
                r_write    <= mem_write;
                r_strobe   <= mem_write ? w_strobe : '0;
                r_data     <= w_sdata;
                r_unsigned <= load_unsigned;
            end
            if (r_state == S_WAIT && dresp_data_ok) begin
                r_result <= r_write ? '0 : w_ld_fmt;
            end
        end
    end

    always_comb begin
        dreq_valid  = 1'b0;
        dreq_addr   = '0;
        dreq_size   = '0;
        dreq_write  = 1'b0;
        dreq_strobe = '0;
        dreq_data   = '0;
        result      = '0;
        done        = 1'b0;
        misalign    = 1'b0;
        bubble      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (valid) begin
                    if (!w_memop) begin
                        result = alu_result;
                        done   = 1'b1;
                    end else if (w_misaligned) begin
                        done     = 1'b1;
                        misalign = 1'b1;
                    end else begin
                        bubble = 1'b1;
                    end
                end
            end
            S_WAIT: begin
                dreq_valid  = 1'b1;
                dreq_addr   = r_addr;
                dreq_size   = r_size;
                dreq_write  = r_write;
                dreq_strobe = r_strobe;
                dreq_data   = r_data;
                bubble      = 1'b1;
            end
            S_DONE: begin
                result = r_result;
                done   = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: doc/mem_access.md
# mem_access

Memory-access stage sitting directly downstream of the execute-stage ALU. Takes the ALU result as the effective address, issues a single load or store on the data bus with a valid/data_ok handshake, aligns store data and byte strobes, and sign- or zero-extends load data. Stalls the execute stage via `bubble` while a bus transaction is outstanding. Non-memory instructions pass the ALU result through in zero cycles.

## Interface
- No parameters; data path fixed at 64 bits, bus at 64 bits.
- `clk` in 1: single clock, all state updates on rising edge.
- `reset` in 1: asynchronous, active-low; clears all state immediately on assertion.
- `valid` in 1: execute stage presents an instruction this cycle.
- `alu_result` in 64: ALU result; effective address for memory ops, passthrough value otherwise.
- `wdata` in 64: store data, right-aligned (rs2).
- `mem_read` in 1: instruction is a load.
- `mem_write` in 1: instruction is a store (never both with `mem_read`).
- `msize` in 2: 0 byte, 1 half, 2 word, 3 double.
- `load_unsigned` in 1: zero-extend load result (LBU/LHU/LWU).
- `dreq_valid` out 1: bus request valid.
- `dreq_addr` out 64: request address, naturally aligned copy of `alu_result`.
- `dreq_size` out 2: copy of `msize`.
- `dreq_write` out 1: 1 store, 0 load.
- `dreq_strobe` out 8: byte-lane write enables (0 for loads).
- `dreq_data` out 64: store data shifted into lanes.
- `dresp_data_ok` in 1: bus completes the outstanding request this cycle.
- `dresp_data` in 64: load data, full doubleword, valid with `dresp_data_ok`.
- `result` out 64: value to writeback.
- `done` out 1: `result` valid; instruction leaves this stage this cycle.
- `misalign` out 1: memory op address not aligned to `msize`; qualifies `done`.
- `bubble` out 1: stall execute stage; upstream holds all inputs stable while high.

## Operation
- States: IDLE, WAIT, DONE. Reset → IDLE.
- Alignment: misaligned when `alu_result[msize-1:0] != 0` (byte never misaligned).
- IDLE, `valid` low: `done`=0, `bubble`=0.
- IDLE, `valid`, no mem op: `result`=`alu_result`, `done`=1, `bubble`=0, same cycle, combinational.
- IDLE, `valid`, mem op, misaligned: `result`=0, `done`=1, `misalign`=1, no bus request, stay IDLE.
- IDLE, `valid`, mem op, aligned: latch addr, size, write, strobe, shifted data, unsigned flag; `bubble`=1, `done`=0; → WAIT.
- WAIT: `dreq_*` driven from latched registers, `dreq_valid`=1, `bubble`=1. On `dresp_data_ok`: load → register formatted data into result reg; store → result reg = 0; → DONE.
- DONE: `done`=1, `bubble`=0, `result`=result reg, `dreq_valid`=0; → IDLE unconditionally. A new instruction presented in DONE is not examined until IDLE.
- Strobe: byte `8'h01<<off`, half `8'h03<<off`, word `8'h0F<<off`, double `8'hFF`; off=`addr[2:0]`.
- Store data: `wdata << (8*off)`.
- Load format: `dresp_data >> (8*off)`, then keep low 8/16/32/64 bits, sign-extend from top kept bit unless `load_unsigned` (ignored for double).
- `dreq_valid` never drops in WAIT before `dresp_data_ok`; request fields stable throughout WAIT.

## Timing
- Reset values: `dreq_valid`=0, `dreq_addr`=0, `dreq_size`=0, `dreq_write`=0, `dreq_strobe`=0, `dreq_data`=0, `result`=0, `done`=0, `misalign`=0, `bubble`=0 (outputs combinational with `valid`; with `valid` low all 0).
- Passthrough and misaligned: latency 0.
- Memory op: accept cycle 0, `dreq_valid` from cycle 1; `dresp_data_ok` in cycle k≥1 → `done` in cycle k+1. Minimum 2 cycles after accept.
- `dresp_data_ok` outside WAIT ignored.
- Reset asserted in WAIT or DONE: immediate return to IDLE, `dreq_valid` and `done` drop asynchronously; in-flight request abandoned (bus reset together).

## Test plan
- Passthrough: `valid`, no mem op, `alu_result`=0x1234 → same-cycle `done`=1, `result`=0x1234, `bubble`=0, `dreq_valid`=0.
- LB sign: addr 0x1003, msize 0, bus returns 0x00000000_80000000 → strobe 0, `result`=0xFFFFFFFF_FFFFFF80 after data_ok+1; LBU same → 0x80.
- SW: addr 0x2004, wdata 0xDEADBEEF → `dreq_strobe`=0xF0, `dreq_data`=0xDEADBEEF_00000000, `dreq_write`=1; `result`=0.
- Handshake stall: data_ok delayed 5 cycles → `dreq_valid` and fields stable 5 cycles, `bubble`=1 throughout, `done` exactly one cycle later.
- Misaligned: LW at 0x1002 → same-cycle `done`=1, `misalign`=1, no `dreq_valid`.
- Reset mid-op: assert `reset` low in WAIT → `dreq_valid`=0 immediately; after release next aligned LD completes normally.
